// File: rtl/fifo8x16_pkg.sv
// fifo8x16_pkg: fifo8_defs constants (include-guarded) and shared pointer/count/data types.
`ifndef FIFO8_DEFS_VH
`define FIFO8_DEFS_VH
`define FIFO8_DEPTH 8
`define FIFO8_PTR_W 3
`define FIFO8_CNT_W 4
`define FIFO8_DATA_W 16
`endif
package fifo8x16_pkg;
  localparam int DEPTH = `FIFO8_DEPTH;
  typedef logic [`FIFO8_PTR_W-1:0] ptr_t;
  typedef logic [`FIFO8_CNT_W-1:0] cnt_t;
  typedef logic [`FIFO8_DATA_W-1:0] data_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
endpackage

// File: rtl/fifo8x16_if.sv
// fifo8x16_if: producer/consumer handshake bundle; slave is the FIFO side.
import fifo8x16_pkg::*;
interface fifo8x16_if;
  data_t in_data;
  logic  in_valid;
  logic  in_ready;
  data_t out_data;
  logic  out_valid;
  logic  out_ready;
  cnt_t  count;
  logic  almost_full;
  modport slave (input in_data, in_valid, out_ready,
                 output in_ready, out_data, out_valid, count, almost_full);
  modport master (output in_data, in_valid, out_ready,
                  input in_ready, out_data, out_valid, count, almost_full);
endinterface

// File: rtl/fifo8x16_reg_bank.sv
// reg_bank8x16: eight 16-bit registers with wr_ptr write decode and a Mux8Way16 read port.
import fifo8x16_pkg::*;
module mux8way16 (
  input  logic [DEPTH-1:0][`FIFO8_DATA_W-1:0] d_i,
  input  ptr_t                                sel_i,
  output data_t                               out_o
);
  assign out_o = d_i[sel_i];
endmodule

module reg_bank8x16 (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we_i,
  input  ptr_t  wr_ptr_i,
  input  data_t wr_data_i,
  input  ptr_t  rd_ptr_i,
  output data_t rd_data_o
);
  logic [DEPTH-1:0][`FIFO8_DATA_W-1:0] mem_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else if (we_i) mem_q[wr_ptr_i] <= wr_data_i;
  end
  mux8way16 u_mux (.d_i(mem_q), .sel_i(rd_ptr_i), .out_o(rd_data_o));
endmodule

// File: rtl/fifo8x16.sv
// fifo8x16: 8x16 first-word-fall-through FIFO; pointers, count and handshakes.
// FIFO8_CLEAR_EN adds clear_i, which empties the FIFO with priority over push/pop.
import fifo8x16_pkg::*;
module fifo8x16 #(
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FIFO8_CLEAR_EN
  input  logic clear_i,
`endif
  fifo8x16_if.slave bus
);
  localparam cnt_t AF_LVL = cnt_t'(ALMOST_FULL_LVL);
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic clr, push, pop;
`ifdef FIFO8_CLEAR_EN
  assign clr = clear_i;
`else
  assign clr = 1'b0;
`endif
  assign bus.in_ready    = count_q != FULL_CNT;
  assign bus.out_valid   = count_q != '0;
  assign bus.count       = count_q;
  assign bus.almost_full = count_q >= AF_LVL;
  // in_ready is left high during clear, so the handshake itself must be gated
  assign push = bus.in_valid & bus.in_ready & ~clr;
  assign pop  = bus.out_valid & bus.out_ready & ~clr;
  always_comb begin
    wr_ptr_d = clr ? '0 : push ? wr_ptr_q + 3'd1 : wr_ptr_q;
    rd_ptr_d = clr ? '0 : pop ? rd_ptr_q + 3'd1 : rd_ptr_q;
    count_d  = clr ? '0 : count_q + {3'b0, push} - {3'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  reg_bank8x16 u_bank (
    .clk(clk), .rst_n(rst_n), .we_i(push), .wr_ptr_i(wr_ptr_q),
    .wr_data_i(bus.in_data), .rd_ptr_i(rd_ptr_q), .rd_data_o(bus.out_data)
  );
endmodule

// File: tb/tb_fifo8x16.sv
// tb_fifo8x16: directed stimulus with a scoreboard queue checked by a separate monitor.
module tb_fifo8x16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int mcnt = 0;
  logic [15:0] exp_q[$];
  fifo8x16_if bus();
  fifo8x16 #(.ALMOST_FULL_LVL(6)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FIFO8_CLEAR_EN
    .clear_i(clr),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT completes a pop
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready && !clr) begin
      if (exp_q.size() == 0) chk("unexpected_pop", bus.out_data, 16'hxxxx);
      else chk("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  task automatic cycle(input logic v, input logic [15:0] d, input logic r, input logic c);
    logic mp, mo;
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.out_ready = r; clr = c;
    @(posedge clk);
    mp = v && mcnt != 8;
    mo = r && mcnt != 0;
    if (c) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      if (mp) exp_q.push_back(d);
      mcnt = mcnt + int'(mp) - int'(mo);
    end
    #1;
    chk("count", {12'h0, bus.count}, 16'(mcnt));
    chk("in_ready", {15'h0, bus.in_ready}, {15'h0, mcnt != 8});
    chk("out_valid", {15'h0, bus.out_valid}, {15'h0, mcnt != 0});
    chk("almost_full", {15'h0, bus.almost_full}, {15'h0, mcnt >= 6});
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    #1;
    chk("rst_count", {12'h0, bus.count}, 16'h0);
    chk("rst_in_ready", {15'h0, bus.in_ready}, 16'h1);
    chk("rst_out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    // fill 0001..0008 with consumer stalled, then drain
    for (int i = 1; i <= 8; i++) cycle(1, 16'(i), 0, 0);
    chk("full_count", {12'h0, bus.count}, 16'd8);
    cycle(1, 16'h00FF, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 16'h0, 1, 0);
    chk("drained_valid", {15'h0, bus.out_valid}, 16'h0);
    cycle(0, 16'h0, 1, 0);
    // wrap-around: pointers land on 5, then 6 words cross 7->0
    for (int i = 0; i < 5; i++) cycle(1, 16'h0100 + 16'(i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 16'h0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 16'hA000 + 16'(i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 1, 0);
    chk("wrap_count", {12'h0, bus.count}, 16'h0);
    // simultaneous push/pop at count 3
    for (int i = 0; i < 3; i++) cycle(1, 16'h3000 + 16'(i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 16'h3100 + 16'(i), 1, 0);
    chk("simul_count", {12'h0, bus.count}, 16'd3);
    // full back-pressure: BEEF held off while a pop frees one slot
    for (int i = 0; i < 5; i++) cycle(1, 16'h4000 + 16'(i), 0, 0);
    cycle(1, 16'hBEEF, 1, 0);
    chk("bp_count", {12'h0, bus.count}, 16'd7);
    cycle(1, 16'hBEEF, 0, 0);
    chk("bp_push_count", {12'h0, bus.count}, 16'd8);
    for (int i = 0; i < 8; i++) cycle(0, 16'h0, 1, 0);
`ifdef FIFO8_CLEAR_EN
    for (int i = 0; i < 4; i++) cycle(1, 16'h5000 + 16'(i), 0, 0);
    cycle(1, 16'hC1EA, 1, 1);
    chk("clr_count", {12'h0, bus.count}, 16'h0);
    cycle(1, 16'h6001, 0, 0);
    cycle(0, 16'h0, 1, 0);
`endif
    // async reset mid-cycle with count 5
    for (int i = 0; i < 5; i++) cycle(1, 16'h7000 + 16'(i), 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", {12'h0, bus.count}, 16'h0);
    chk("arst_out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("arst_in_ready", {15'h0, bus.in_ready}, 16'h1);
    chk("arst_out_data", bus.out_data, 16'h0000);
    mcnt = 0;
    exp_q.delete();
    bus.in_valid = 0; bus.out_ready = 0;
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 16'h8001, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 0, 0);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo8x16.md
Name: fifo8x16

Overview:
- 8-entry × 16-bit first-word-fall-through FIFO built from eight 16-bit registers.
- The read side feeds the Mux8Way16 read-select path: the read pointer drives the mux sel, and the mux output is the FIFO head word.
- It sits between a 16-bit word producer (e.g. ALU result or I/O capture) and a consumer that drains at its own rate.
- Valid/ready handshake on both sides.

Parameters:
- ALMOST_FULL_LVL, 6, count threshold at or above which almost_full asserts; legal range 1..8.
- Data width is fixed at 16 and depth at 8 by the Mux8Way16 read path. These are not parameters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  16  word to push.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  FIFO can accept; equals (count != 8).
- out_data  output  16  head word; mux of storage[rd_ptr] through Mux8Way16.
- out_valid  output  1  head word is valid; equals (count != 0).
- out_ready  input  1  consumer accepts the head word.
- count  output  4  occupancy, 0..8.
- almost_full  output  1  equals (count >= ALMOST_FULL_LVL).
- clear  input  1  present only with FIFO8_CLEAR_EN.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - On rst_n low, immediately and regardless of clk: wr_ptr=0, rd_ptr=0, count=0, all eight storage registers=16'h0000.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=16'h0000, almost_full=0 (ALMOST_FULL_LVL≥1).
- Push and pop events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- On push: storage[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1, 3-bit wrap 7→0.
- On pop: rd_ptr <= rd_ptr+1, 3-bit wrap 7→0. The storage word is left unchanged.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Simultaneous push and pop:
  - Legal at any count 1..7.
  - At count=8, in_ready=0, so no push occurs even if a pop occurs that cycle. in_ready does not depend on out_ready, so there is no combinational ready path.
  - At count=0, out_valid=0, so no pop occurs. A push into an empty FIFO is not bypassed.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N (first-word-fall-through, 1-cycle latency).
- Output timing:
  - out_data is combinational from storage and rd_ptr only.
  - It is stable while out_valid=1 and no pop occurs.
  - When empty, it shows storage[rd_ptr] (stale data); consumers qualify it with out_valid.
- Full/empty boundaries:
  - in_valid while full: the word is held off, not dropped. The producer must hold it.
  - out_ready while empty: ignored.
- Pointer relation: wr_ptr == rd_ptr holds both when empty and when full; count disambiguates the two cases.
- Reset mid-transfer: any in-flight handshake that cycle is discarded. The FIFO returns to empty.

Optional Feature:
- Macro: FIFO8_CLEAR_EN.
- Defined:
  - Adds input clear.
  - clear=1 at an edge sets wr_ptr=rd_ptr=0 and count=0, with priority over push/pop in that same cycle.
  - Storage is not cleared.
  - in_ready stays 1 during clear; a word offered that cycle is not accepted.
- Undefined: the clear port is absent and behaviour is exactly as above.

Decomposition:
- Shared include header fifo8_defs.vh, with include guard, holding `define constants:
  - FIFO8_DEPTH=8, FIFO8_PTR_W=3, FIFO8_CNT_W=4, FIFO8_DATA_W=16.
- One sub-module, reg_bank8x16:
  - Eight 16-bit registers with async active-low reset.
  - Write-enable decode from wr_ptr.
  - Read port built from one Mux8Way16 instance with sel=rd_ptr.
- fifo8x16 itself holds the pointers, count, and handshake logic.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with count=5 → immediately count=0, out_valid=0, in_ready=1, out_data=16'h0000.
- Fill/drain: push 16'h0001..16'h0008 with out_ready=0 →
  - count=8, in_ready=0, almost_full=1 from count=6.
  - Then pop 8 with out_ready=1 → out_data sequence 0001..0008, then out_valid=0.
- Wrap-around: push 5, pop 5, then push 16'hA000..16'hA005 and pop all → exact order preserved across the 7→0 pointer wrap; count returns to 0.
- Simultaneous: at count=3, hold in_valid=out_ready=1 for 10 cycles with incrementing data → count stays 3 and output order is strictly FIFO.
- Full back-pressure: at count=8, drive in_valid=1 with data 16'hBEEF and out_ready=1 for one cycle →
  - That cycle: pop only, count=7, 16'hBEEF not written.
  - Next cycle: in_ready=1, push succeeds.
- FIFO8_CLEAR_EN build: at count=4, pulse clear together with in_valid=1 and out_ready=1 → count=0, out_valid=0, and the offered word is not stored.
